// File: rtl/copro_result_buffer_if.sv
// -----------------------------------------------------------------------------
// copro_result_buffer_if
//
// Purpose:
//   Bundles the ALU push side, the core-facing result side and the status
//   outputs of copro_result_buffer into a single interface. Clock and reset
//   are not part of the bundle; they stay as plain module ports.
//
// Signals (direction as seen from the buffer, i.e. the slave modport):
//   flush_i        in   synchronous clear of all stored entries
//   alu_valid_i    in   ALU result present this cycle (no backpressure)
//   alu_result_i   in   ALU result data, XLEN bits
//   alu_hartid_i   in   hart of the result
//   alu_id_i       in   instruction id of the result
//   alu_rd_i       in   destination register
//   alu_we_i       in   register write enable
//   accept_o       out  issue may send one more instruction to the ALU
//   result_valid_o out  head entry presented to the core
//   result_ready_i in   core consumes the head entry
//   result_data_o, hartid_o, id_o, rd_o, we_o  out  head entry fields
//   count_o        out  number of stored entries
//   overflow_o     out  sticky flag, a push was lost
//
// Modports:
//   master - ALU / core / issue side (drives inputs of the buffer)
//   slave  - the buffer itself
// -----------------------------------------------------------------------------
interface copro_result_buffer_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic             alu_valid_i;
    logic [XLEN-1:0]  alu_result_i;
    hartid_t          alu_hartid_i;
    id_t              alu_id_i;
    logic [4:0]       alu_rd_i;
    logic             alu_we_i;
    logic             accept_o;
    logic             result_valid_o;
    logic             result_ready_i;
    logic [XLEN-1:0]  result_data_o;
    hartid_t          hartid_o;
    id_t              id_o;
    logic [4:0]       rd_o;
    logic             we_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    modport master (
        output flush_i,
        output alu_valid_i,
        output alu_result_i,
        output alu_hartid_i,
        output alu_id_i,
        output alu_rd_i,
        output alu_we_i,
        output result_ready_i,
        input  accept_o,
        input  result_valid_o,
        input  result_data_o,
        input  hartid_o,
        input  id_o,
        input  rd_o,
        input  we_o,
        input  count_o,
        input  overflow_o
    );

    modport slave (
        input  flush_i,
        input  alu_valid_i,
        input  alu_result_i,
        input  alu_hartid_i,
        input  alu_id_i,
        input  alu_rd_i,
        input  alu_we_i,
        input  result_ready_i,
        output accept_o,
        output result_valid_o,
        output result_data_o,
        output hartid_o,
        output id_o,
        output rd_o,
        output we_o,
        output count_o,
        output overflow_o
    );

endinterface

// File: rtl/copro_result_buffer.sv
// -----------------------------------------------------------------------------
// copro_result_buffer
//
// Purpose:
//   Circular FIFO that collects results from a 1-cycle coprocessor ALU and
//   presents them in order to the core. The ALU side cannot be stalled, so
//   accept_o throttles issue early enough to leave room for the result that
//   is already in flight. A push that still finds the buffer full (and no
//   pop in the same cycle) is dropped and recorded in the sticky overflow_o.
//
// Parameters:
//   XLEN     result data width
//   DEPTH    number of entries; power of two, at least 2
//   hartid_t hart identifier type
//   id_t     instruction identifier type
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_ni   asynchronous active-low reset
//   bus      copro_result_buffer_if.slave (push side, result side, status)
// -----------------------------------------------------------------------------
module copro_result_buffer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    copro_result_buffer_if.slave    bus
);

    localparam int unsigned        PTR_W      = $clog2(DEPTH);
    localparam int unsigned        CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   ACCEPT_MAX = CNT_W'(DEPTH - 2);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    // Entry storage; data path only, no reset needed because the outputs
    // are masked while the buffer is empty.
    logic [XLEN-1:0]  r_data [DEPTH];
    hartid_t          r_hart [DEPTH];
    id_t              r_id   [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic             r_we   [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_write;
    logic             w_drop;

    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == FULL_CNT);
        w_pop   = w_valid && bus.result_ready_i && !bus.flush_i;
        // A pop in the same cycle frees the head slot, so a full buffer can
        // still take the push: the new entry lands in the slot being vacated
        // (write pointer equals read pointer when full).
        w_write = bus.alu_valid_i && (!w_full || w_pop) && !bus.flush_i;
        w_drop  = bus.alu_valid_i && w_full && !w_pop && !bus.flush_i;
    end

    // Control state: pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_data[r_wr_ptr] <= bus.alu_result_i;
            r_hart[r_wr_ptr] <= bus.alu_hartid_i;
            r_id[r_wr_ptr]   <= bus.alu_id_i;
            r_rd[r_wr_ptr]   <= bus.alu_rd_i;
            r_we[r_wr_ptr]   <= bus.alu_we_i;
        end
    end

    // Head entry presentation; fields read as zero while empty so that
    // reset forces every output field to zero without clearing the storage.
    always_comb begin
        bus.result_valid_o = w_valid;
        bus.result_data_o  = w_valid ? r_data[r_rd_ptr] : '0;
        bus.hartid_o       = w_valid ? r_hart[r_rd_ptr] : hartid_t'('0);
        bus.id_o           = w_valid ? r_id[r_rd_ptr]   : id_t'('0);
        bus.rd_o           = w_valid ? r_rd[r_rd_ptr]   : '0;
        bus.we_o           = w_valid ? r_we[r_rd_ptr]   : 1'b0;
        bus.count_o        = r_count;
        bus.overflow_o     = r_overflow;
        // Leave one free slot for the result already inside the ALU.
        bus.accept_o       = (r_count <= ACCEPT_MAX);
    end

endmodule

// File: doc/copro_result_buffer.md
COPRO_RESULT_BUFFER -- requirements
Module: copro_result_buffer

Interface
REQ-001 Parameter XLEN, default 32, result data width in bits.
REQ-002 Parameter DEPTH, default 4, number of result entries; legal values are powers of two, at least 2.
REQ-003 Parameter hartid_t, default logic, hart identifier type.
REQ-004 Parameter id_t, default logic, instruction identifier type.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset; asynchronous, active-low.
REQ-007 flush_i  input  1  synchronous clear of all stored entries.
REQ-008 alu_valid_i  input  1  ALU result present this cycle; no backpressure on this side.
REQ-009 alu_result_i  input  XLEN  ALU result data.
REQ-010 alu_hartid_i  input  hartid_t  hart of the result.
REQ-011 alu_id_i  input  id_t  instruction id of the result.
REQ-012 alu_rd_i  input  5  destination register.
REQ-013 alu_we_i  input  1  register write enable.
REQ-014 accept_o  output  1  issue may send one more instruction to the ALU this cycle.
REQ-015 result_valid_o  output  1  head entry presented to the core.
REQ-016 result_ready_i  input  1  core consumes the head entry when high together with result_valid_o.
REQ-017 result_data_o, hartid_o, id_o, rd_o, we_o  output  XLEN/hartid_t/id_t/5/1  head entry fields.
REQ-018 count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-019 overflow_o  output  1  sticky flag; a push was lost.

Function
REQ-020 Storage SHALL be a circular FIFO with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-021 A push SHALL occur on each cycle with alu_valid_i=1, regardless of alu_we_i; entries with we=0 are stored and reported.
REQ-022 A pop SHALL occur on each cycle with result_valid_o=1 and result_ready_i=1.
REQ-023 result_valid_o SHALL equal (count_o != 0); the output fields SHALL come from the head entry; there is no combinational bypass, so latency from push to result_valid_o is exactly 1 cycle.
REQ-024 Output fields SHALL remain stable while result_valid_o=1 and result_ready_i=0.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, including when the FIFO is full or holds exactly one entry.
REQ-026 accept_o SHALL be 1 only when count_o <= DEPTH-2, which covers the one result already in flight inside the 1-cycle ALU.
REQ-027 A push when count_o == DEPTH and no pop occurs in the same cycle SHALL be dropped and SHALL set overflow_o; FIFO contents and count are unchanged.
REQ-028 overflow_o SHALL clear only on reset or flush_i.
REQ-029 flush_i=1 SHALL, at the next edge, set count to 0, both pointers to 0 and overflow_o to 0; a push or pop in the same cycle is discarded.
REQ-030 count_o SHALL never exceed DEPTH and never underflow; a pop is impossible when empty because result_valid_o=0.

Reset
REQ-031 On rst_ni low, asynchronously: count_o=0, pointers=0, result_valid_o=0, overflow_o=0, accept_o=1, and all output fields = 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; the first push after reset SHALL be presented at entry 0.

Verification
REQ-033 Single pass-through: push result=0x0000_0005, id=1, rd=3, we=1 with ready=1 -> result_valid_o high exactly 1 cycle later with those fields; count returns to 0 the following cycle.
REQ-034 Backpressure fill, DEPTH=4, ready=0: four pushes of ids 0..3 -> accept_o falls when count reaches 3; count_o=4; the head holds id 0 and stays stable; raise ready -> ids pop in order 0,1,2,3, one per cycle.
REQ-035 Full plus simultaneous push and pop: count=4, push id 7 with ready=1 -> count stays 4, id 0 is popped, id 7 is stored at the tail, overflow_o=0.
REQ-036 Overflow: count=4, ready=0, push id 9 -> overflow_o=1 and stays 1; id 9 never appears at the output.
REQ-037 NOP entry: push with we=0, rd=0, result=0 -> presented with we_o=0 and counted normally.
REQ-038 Flush and reset mid-stream: count=3 plus flush_i with a concurrent push -> count_o=0, result_valid_o=0, overflow_o=0 next cycle; rst_ni pulse during traffic -> all outputs 0 immediately, and pointer wrap is correct over 10 or more subsequent pushes and pops.
